// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - rate codes, puncture tables and default generators for conv_encoder_punct
package conv_enc_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  typedef enum logic {
    ST_RUN,
    ST_TAIL
  } tail_state_e;

  localparam logic [6:0] G0_DEFAULT = 7'o133;
  localparam logic [6:0] G1_DEFAULT = 7'o171;
  localparam int         TAIL_CNT_W = 4;

  // Keep mask indexed [rate][phase]: bit 1 keeps generator A, bit 0 keeps generator B.
  localparam logic [1:0] KEEP_MASK [4][3] = '{
    '{2'b11, 2'b11, 2'b11},
    '{2'b11, 2'b10, 2'b11},
    '{2'b11, 2'b10, 2'b01},
    '{2'b11, 2'b11, 2'b11}
  };

  localparam logic [1:0] PHASE_MOD [4] = '{2'd1, 2'd2, 2'd3, 2'd1};

  function automatic rate_e norm_rate(input logic [1:0] r);
    return (r == 2'b11) ? RATE_1_2 : rate_e'(r);
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] ph, input rate_e r);
    return ((ph + 2'd1) == PHASE_MOD[r]) ? 2'd0 : ph + 2'd1;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - K-1 bit shift register and the two generator parity trees
module conv_enc_core
  import conv_enc_pkg::*;
#(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = K'(G0_DEFAULT),
  parameter logic [K-1:0] G1 = K'(G1_DEFAULT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift_en,
  input  logic in_bit,
  output logic enc_a,
  output logic enc_b
);

  logic [K-2:0] sreg_q, sreg_d;
  logic [K-1:0] taps;

  // sreg_q[K-2] is the bit delayed by one, sreg_q[0] the oldest.
  always_comb begin
    taps   = {in_bit, sreg_q};
    enc_a  = ^(G0 & taps);
    enc_b  = ^(G1 & taps);
    sreg_d = sreg_q;
    if (clear) begin
      sreg_d = '0;
    end else if (shift_en) begin
      sreg_d = {in_bit, sreg_q[K-2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/conv_encoder_punct.sv
// rtl/conv_encoder_punct.sv - punctured convolutional encoder, 1 bit/cycle serial out
// Optional macro CONV_ENC_TAIL_EN: append K-1 zero tail bits after iInLast.
module conv_encoder_punct
  import conv_enc_pkg::*;
#(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = K'(G0_DEFAULT),
  parameter logic [K-1:0] G1 = K'(G1_DEFAULT)
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iClear,
  input  logic [1:0] iRate,
  input  logic       iInValid,
  input  logic       iInData,
  input  logic       iInLast,
  output logic       oInReady,
  output logic       oOutValid,
  output logic       oOutData,
  output logic       oOutLast,
  input  logic       iOutReady
);

`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic [1:0]            count_q, count_d;
  logic [1:0]            buf_q, buf_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            phase_q, phase_d;
  rate_e                 rate_q, rate_d;
  tail_state_e           state_q, state_d;
  logic [TAIL_CNT_W-1:0] tail_cnt_q, tail_cnt_d;

  logic       pop, can_load, in_ready, accept, tail_step, enc_step, enc_bit, frame_end;
  logic       enc_a, enc_b;
  logic [1:0] keep;

  conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk      (iClk),
    .rst_n    (iRstN),
    .clear    (iClear),
    .shift_en (enc_step),
    .in_bit   (enc_bit),
    .enc_a    (enc_a),
    .enc_b    (enc_b)
  );

  always_comb begin
    count_d    = count_q;
    buf_d      = buf_q;
    last_d     = last_q;
    phase_d    = phase_q;
    rate_d     = rate_q;
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    frame_end  = 1'b0;

    pop       = (count_q != 2'd0) && iOutReady;
    // Loading is allowed when the buffer will be empty after this cycle's pop.
    can_load  = (count_q == 2'd0) || ((count_q == 2'd1) && iOutReady);
    in_ready  = can_load && (state_q == ST_RUN) && !iClear;
    accept    = iInValid && in_ready;
    tail_step = TAIL_EN && (state_q == ST_TAIL) && can_load && !iClear;
    enc_step  = accept || tail_step;
    enc_bit   = accept && iInData;
    keep      = KEEP_MASK[rate_q][phase_q];

    if (pop) begin
      buf_d   = {buf_q[1], buf_q[1]};
      last_d  = {last_q[1], last_q[1]};
      count_d = count_q - 2'd1;
    end

    if (enc_step) begin
      if (TAIL_EN) begin
        if (accept && iInLast) begin
          state_d    = ST_TAIL;
          tail_cnt_d = TAIL_CNT_W'(K - 1);
        end else if (tail_step) begin
          tail_cnt_d = tail_cnt_q - TAIL_CNT_W'(1);
          if (tail_cnt_q == TAIL_CNT_W'(1)) begin
            frame_end = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end else begin
        frame_end = accept && iInLast;
      end

      case (keep)
        2'b11: begin
          buf_d   = {enc_b, enc_a};
          last_d  = {frame_end, 1'b0};
          count_d = 2'd2;
        end
        2'b10: begin
          buf_d[0]  = enc_a;
          last_d[0] = frame_end;
          count_d   = 2'd1;
        end
        default: begin
          buf_d[0]  = enc_b;
          last_d[0] = frame_end;
          count_d   = 2'd1;
        end
      endcase

      phase_d = frame_end ? 2'd0 : next_phase(phase_q, rate_q);
    end

    if (iClear) begin
      count_d    = 2'd0;
      last_d     = 2'b00;
      phase_d    = 2'd0;
      rate_d     = norm_rate(iRate);
      state_d    = ST_RUN;
      tail_cnt_d = '0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      count_q    <= 2'd0;
      buf_q      <= 2'b00;
      last_q     <= 2'b00;
      phase_q    <= 2'd0;
      rate_q     <= RATE_1_2;
      state_q    <= ST_RUN;
      tail_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      phase_q    <= phase_d;
      rate_q     <= rate_d;
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  assign oInReady  = in_ready;
  assign oOutValid = (count_q != 2'd0);
  assign oOutData  = buf_q[0];
  assign oOutLast  = last_q[0] && (count_q != 2'd0);

endmodule
